// File: rtl/fir_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_ctrl_pkg
//  Purpose  : Shared types and constants for the FIR sample sequencer.
//             - state_e        : result-gating state (PRIME while the FIR sum
//                                pipeline is still warming up, RUN afterwards)
//             - FIR_PIPE_DEPTH : strobes before the FIR output reflects a
//                                real sample
//             - OVF_CNT_W      : width of the dropped-push counter
//  Revision : 1.0  initial release
// ============================================================================
package fir_stream_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int FIR_PIPE_DEPTH = 2;
  localparam int OVF_CNT_W      = 16;

endpackage : fir_stream_ctrl_pkg
`default_nettype wire

// File: rtl/fir_stream_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_ctrl_sync_fifo
//  Purpose  : Small synchronous FIFO buffering incoming samples.
//             A push on a full FIFO is accepted only when a pop happens in
//             the same cycle. There is no bypass: a push into an empty FIFO
//             becomes visible at the head on the following cycle.
//  Ports    : clk, rst     clock / asynchronous active-high reset
//             push_i       push request
//             data_i       push data
//             pop_i        pop request (ignored when empty)
//             data_o       head entry
//             level_o      occupancy, 0..DEPTH
//             full_o       level_o == DEPTH
//             empty_o      level_o == 0
//  Revision : 1.0  initial release
// ============================================================================
module fir_stream_ctrl_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

endmodule : fir_stream_ctrl_sync_fifo
`default_nettype wire

// File: rtl/fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_stream_ctrl
//  Purpose  : Sample sequencer for the 17-tap FIR. Buffers pushed samples,
//             issues one FIR advance strobe per sample, captures the FIR
//             result one cycle after each strobe, drops the warm-up results,
//             decimates by DECIM and presents the survivors on a
//             valid/ready stream.
//  Ports    : clk, rst        clock / asynchronous active-high reset
//             in_valid/data   sample push (no back-pressure; drops on full)
//             fir_strobe_o    one-cycle FIR advance (start_i, merge_finished_i)
//             fir_data_o      sample for FIR data_i, held until next pop
//             fir_result_i    FIR data_o
//             out_valid/ready/data   result stream
//             fifo_level      input FIFO occupancy
//             ovf_o           sticky dropped-push flag
//             ovf_cnt_o       dropped-push count
//  Macro    : FIR_STREAM_OVF_CNT_EN builds the saturating dropped-push
//             counter; otherwise ovf_cnt_o is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module fir_stream_ctrl
  import fir_stream_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PRIME      = FIR_PIPE_DEPTH,
  parameter int DECIM      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          fir_strobe_o,
  output logic [WIDTH-1:0]              fir_data_o,
  input  logic [WIDTH-1:0]              fir_result_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_o,
  output logic [OVF_CNT_W-1:0]          ovf_cnt_o
);

  state_e           state_q, state_d;
  logic [7:0]       prime_cnt_q, prime_cnt_d;
  logic [7:0]       decim_cnt_q, decim_cnt_d;
  logic [7:0]       decim_nxt;
  logic             strobe_q, strobe_d;
  logic             cap_q;
  logic [WIDTH-1:0] fir_data_q, fir_data_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             ovf_q, ovf_d;
  logic             load_pending, slot_free, drop;

  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full, fifo_empty;

  fir_stream_ctrl_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (strobe_d),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign decim_nxt = (decim_cnt_q == 8'(DECIM - 1)) ? 8'd0 : decim_cnt_q + 8'd1;

  // A capture in progress that will land in the output slot reserves it:
  // a strobe issued now would capture two cycles later, and without this
  // reservation it could overwrite a result the consumer has not taken.
  assign load_pending = cap_q && (state_q == ST_RUN) && (decim_nxt == 8'd0);
  assign slot_free    = !load_pending && (!out_valid_q || out_ready);
  assign strobe_d     = !fifo_empty && !strobe_q && slot_free;
  assign drop         = in_valid && fifo_full && !strobe_d;

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    decim_cnt_d = decim_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fir_data_d  = fir_data_q;
    ovf_d       = ovf_q || drop;

    if (strobe_d) fir_data_d = fifo_head;

    // Handshake first so a same-cycle capture can refill the slot.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_PRIME: begin
        if (cap_q) begin
          if (prime_cnt_q == 8'(PRIME - 1)) begin
            state_d     = ST_RUN;
            prime_cnt_d = 8'd0;
          end else begin
            prime_cnt_d = prime_cnt_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (cap_q) begin
          decim_cnt_d = decim_nxt;
          if (decim_nxt == 8'd0) begin
            out_valid_d = 1'b1;
            out_data_d  = fir_result_i;
          end
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= 8'd0;
      decim_cnt_q <= 8'd0;
      strobe_q    <= 1'b0;
      cap_q       <= 1'b0;
      fir_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      decim_cnt_q <= decim_cnt_d;
      strobe_q    <= strobe_d;
      cap_q       <= strobe_q;   // FIR result for a strobe is valid one cycle later
      fir_data_q  <= fir_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fir_strobe_o = strobe_q;
  assign fir_data_o   = fir_data_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign ovf_o        = ovf_q;

`ifdef FIR_STREAM_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt_o = ovf_cnt_q;
`else
  assign ovf_cnt_o = '0;
`endif

endmodule : fir_stream_ctrl
`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_stream_ctrl
//  Purpose  : Self-checking bench. Two sequencers (DECIM=1 and DECIM=4)
//             share all stimulus; each drives its own behavioural 17-tap FIR
//             (coefficients 1..17, two-strobe output delay). A per-cycle
//             scoreboard tracks FIFO contents, drops, strobed samples and the
//             expected result stream for each instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_stream_ctrl;

`ifdef FIR_STREAM_OVF_CNT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam int PRIME_N = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        strobe [2];
  logic [31:0] fdata  [2];
  logic [31:0] fres   [2];
  logic        ov     [2];
  logic [31:0] od     [2];
  logic [2:0]  lvl    [2];
  logic        ovf    [2];
  logic [15:0] ocnt   [2];

  always #5 clk = ~clk;

  fir_stream_ctrl #(.WIDTH(32), .FIFO_DEPTH(4), .PRIME(2), .DECIM(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .fir_strobe_o(strobe[0]), .fir_data_o(fdata[0]), .fir_result_i(fres[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .fifo_level(lvl[0]), .ovf_o(ovf[0]), .ovf_cnt_o(ocnt[0]));

  fir_stream_ctrl #(.WIDTH(32), .FIFO_DEPTH(4), .PRIME(2), .DECIM(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .fir_strobe_o(strobe[1]), .fir_data_o(fdata[1]), .fir_result_i(fres[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .fifo_level(lvl[1]), .ovf_o(ovf[1]), .ovf_cnt_o(ocnt[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- sample histories and FIR arithmetic ----------------
  logic [31:0] fh [2][1024];   // samples seen by the environment FIR
  int          fn [2];
  logic [31:0] mh [2][1024];   // samples the scoreboard expects were strobed
  int          mn [2];

  function automatic logic [31:0] conv(input int d, input int j, input bit env);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 17; i++) begin
      if (j - i >= 0) acc += 32'(i + 1) * (env ? fh[d][(j - i) & 1023] : mh[d][(j - i) & 1023]);
    end
    return acc;
  endfunction

  // Environment FIR: result after strobe k is y(k-2), zero before that.
  always_ff @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        fn[d]   <= 0;
        fres[d] <= '0;
      end else if (strobe[d]) begin
        fh[d][fn[d] & 1023] <= fdata[d];
        fn[d]               <= fn[d] + 1;
        fres[d]             <= (fn[d] >= PRIME_N) ? conv(d, fn[d] - PRIME_N, 1'b1) : 32'd0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] mq [2][$];
  int          mdrop [2];
  logic        movf [2];
  logic [15:0] mcnt [2];
  logic        mv [2];
  logic [31:0] md [2];
  logic        ldA_v [2], ldB_v [2];
  logic [31:0] ldA_d [2], ldB_d [2];
  logic        prev_hs [2], prev_st [2];
  int          outcnt [2];
  logic [31:0] outlog0 [$];
  logic        prev_v;
  logic [31:0] prev_dat;
  int          sz;
  logic        pop, acc, app;
  logic [31:0] hd, appd;

  initial begin
    prev_v = 1'b0; prev_dat = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          mq[d].delete();
          mn[d] = 0; mdrop[d] = 0; movf[d] = 1'b0; mcnt[d] = '0;
          mv[d] = 1'b0; md[d] = '0; ldA_v[d] = 1'b0; ldB_v[d] = 1'b0;
          prev_hs[d] = 1'b0; prev_st[d] = 1'b0; outcnt[d] = 0;
          if (d == 0) outlog0.delete();
        end else begin
          sz  = mq[d].size();
          pop = strobe[d];
          acc = prev_v && (sz < 4 || pop);
          if (prev_v && !acc) begin
            mdrop[d]++;
            movf[d] = 1'b1;
            if (mcnt[d] != 16'hFFFF) mcnt[d] = mcnt[d] + 16'd1;
          end
          chk(!(prev_st[d] && pop), "strobe_adjacent", 32'(pop), 0);
          app  = ldB_v[d]; appd = ldB_d[d];
          ldB_v[d] = ldA_v[d]; ldB_d[d] = ldA_d[d]; ldA_v[d] = 1'b0;
          if (pop) begin
            if (sz == 0) begin
              chk(1'b0, "pop_empty", 1, 0);
            end else begin
              hd = mq[d].pop_front();
              chk(fdata[d] == hd, "fir_data", fdata[d], hd);
              mh[d][mn[d] & 1023] = hd;
              if (mn[d] >= PRIME_N && ((mn[d] - PRIME_N + 1) % (d == 0 ? 1 : 4)) == 0) begin
                ldA_v[d] = 1'b1;
                ldA_d[d] = conv(d, mn[d] - PRIME_N, 1'b0);
              end
              mn[d]++;
            end
          end
          if (acc) mq[d].push_back(prev_dat);
          if (prev_hs[d]) mv[d] = 1'b0;
          if (app) begin
            chk(!mv[d], "result_overwrite", 32'(mv[d]), 0);
            mv[d] = 1'b1;
            md[d] = appd;
          end
          chk(int'(lvl[d]) == mq[d].size(), "fifo_level", 32'(lvl[d]), 32'(mq[d].size()));
          chk(ovf[d] == movf[d], "ovf", 32'(ovf[d]), 32'(movf[d]));
          chk(ocnt[d] == (OVF_EN ? mcnt[d] : 16'd0), "ovf_cnt", 32'(ocnt[d]), 32'(OVF_EN ? mcnt[d] : 16'd0));
          chk(ov[d] == mv[d], "out_valid", 32'(ov[d]), 32'(mv[d]));
          if (mv[d]) chk(od[d] == md[d], "out_data", od[d], md[d]);
          if (mv[d] && out_ready) begin
            outcnt[d]++;
            if (d == 0) outlog0.push_back(od[d]);
          end
          prev_hs[d] = mv[d] && out_ready;
          prev_st[d] = pop;
        end
      end
      prev_v   = rst ? 1'b0 : in_valid;
      prev_dat = in_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic zero_chk();
    for (int d = 0; d < 2; d++) begin
      chk(strobe[d] == 1'b0, "rst_strobe", 32'(strobe[d]), 0);
      chk(fdata[d] == '0, "rst_fir_data", fdata[d], 0);
      chk(ov[d] == 1'b0, "rst_out_valid", 32'(ov[d]), 0);
      chk(od[d] == '0, "rst_out_data", od[d], 0);
      chk(lvl[d] == '0, "rst_fifo_level", 32'(lvl[d]), 0);
      chk(ovf[d] == 1'b0, "rst_ovf", 32'(ovf[d]), 0);
      chk(ocnt[d] == '0, "rst_ovf_cnt", 32'(ocnt[d]), 0);
    end
  endtask

  task automatic drain();
    int  n;
    bit  idle;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      idle = 1'b1;
      for (int d = 0; d < 2; d++)
        if (mq[d].size() != 0 || mv[d] || ldA_v[d] || ldB_v[d]) idle = 1'b0;
    end while (!idle && n < 400);
    chk(idle, "drain_timeout", n, 400);
    repeat (4) tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state, then DECIM=1 warm-up discard: outputs y(0)=1, y(1)=2+2=4.
    tick();
    zero_chk();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(32'(i));
      repeat (3) tick();
    end
    drain();
    chk(outlog0.size() == 2, "t1_out_count", 32'(outlog0.size()), 2);
    if (outlog0.size() >= 2) begin
      chk(outlog0[0] == 32'd1, "t1_first_result", outlog0[0], 1);
      chk(outlog0[1] == 32'd4, "t1_second_result", outlog0[1], 4);
    end

    // Steady stream: 20 samples; DECIM=4 keeps run captures 3,7,11,15.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(32'($urandom_range(0, 2000)) - 32'd1000);
      repeat (2) tick();
    end
    drain();
    chk(outcnt[1] == 4, "t2_decim4_outputs", outcnt[1], 4);
    chk(outcnt[0] == 18, "t2_decim1_outputs", outcnt[0], 18);
    chk(mdrop[1] == 0, "t2_no_drops", mdrop[1], 0);

    // Back-pressure: slot held, FIFO fills, two pushes dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'(11 + i));
      repeat (3) tick();
    end
    repeat (6) tick();
    for (int i = 0; i < 6; i++) push(32'(20 + i));
    repeat (9) tick();
    chk(lvl[0] == 3'd4, "t3_level_full", 32'(lvl[0]), 4);
    chk(ovf[0] == 1'b1, "t3_ovf_sticky", 32'(ovf[0]), 1);
    chk(ocnt[0] == (OVF_EN ? 16'd2 : 16'd0), "t3_ovf_cnt", 32'(ocnt[0]), OVF_EN ? 2 : 0);
    chk(mdrop[0] == 2, "t3_drop_count", mdrop[0], 2);

    // Full FIFO, push coincides with the pop released by the handshake.
    in_valid  = 1'b1;
    in_data   = 32'd99;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk(lvl[0] == 3'd4, "t4_level_kept", 32'(lvl[0]), 4);
    chk(ocnt[0] == (OVF_EN ? 16'd2 : 16'd0), "t4_no_new_drop", 32'(ocnt[0]), OVF_EN ? 2 : 0);
    drain();

    // Random traffic with random back-pressure, then async reset mid-cycle.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_data   = 32'($urandom_range(0, 2000)) - 32'd1000;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    zero_chk();
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      push(32'(i));
      repeat (3) tick();
    end
    drain();
    chk(outlog0.size() == 1, "t5_reprime_count", 32'(outlog0.size()), 1);
    if (outlog0.size() >= 1) chk(outlog0[0] == 32'd5, "t5_reprime_result", outlog0[0], 5);

`ifdef FIR_STREAM_OVF_CNT_EN
    // Saturation: more than 65535 drops.
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 65560; c++) begin
      in_data = 32'(c);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk(ocnt[0] == 16'hFFFF, "t6_sat_dut1", 32'(ocnt[0]), 32'hFFFF);
    chk(ocnt[1] == 16'hFFFF, "t6_sat_dut4", 32'(ocnt[1]), 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fir_stream_ctrl
`default_nettype wire
